// File: rtl/ame_num_sched_if.sv
// Requester-side bundle: operand quads in with valid/ready, one-hot result strobe out.
// Combinational ready on the slave side; responses carry no backpressure.
// Requesters must hold valid and data stable until they see ready.
interface ame_num_sched_if #(
    parameter int NUM_REQ        = 4,
    parameter int COMP_DATA_BITS = 64
);
    logic [NUM_REQ-1:0]                           req_valid;
    logic [NUM_REQ-1:0]                           req_ready;
    logic [NUM_REQ-1:0][3:0][COMP_DATA_BITS-1:0]  req_data;
    logic [NUM_REQ-1:0]                           rsp_valid;
    logic [COMP_DATA_BITS-1:0]                    rsp_data;

    modport master (
        output req_valid, req_data,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/ame_num_sched.sv
// Round-robin sharing of one pipelined M*D-L*C unit among NUM_REQ solver lanes.
// Latency: handshake -> comp_init next cycle -> response COMP_LATENCY+2 cycles after handshake.
// Backpressure: ready is combinational, one grant per cycle while en_i; responses cannot stall.
module ame_num_sched #(
    parameter int NUM_REQ        = 4,
    parameter int COMP_DATA_BITS = 64,
    parameter int COMP_LATENCY   = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           en_i,
    ame_num_sched_if.slave                 req_if,
    output logic                           comp_init_o,
    output logic [3:0][COMP_DATA_BITS-1:0] comp_data_o,
    input  logic                           comp_done_i,
    input  logic [COMP_DATA_BITS-1:0]      comp_data_i,
    output logic                           busy_o,
    output logic                           err_o
);
    localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int LAST = COMP_LATENCY;
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    logic [PW-1:0]             ptr;
    logic [PW-1:0]             gnt_idx;
    logic                      gnt_any;
    logic [LAST:0]             tag_vld;
    logic [LAST:0][PW-1:0]     tag_idx;
    logic [NUM_REQ-1:0]        rsp_valid_q;
    logic [COMP_DATA_BITS-1:0] rsp_data_q;

    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PW'(s);
    endfunction

    // Scan offsets from the far end so the nearest valid requester after ptr wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (en_i && req_if.req_valid[wrap_idx(ptr, i)]) begin
                gnt_any = 1'b1;
                gnt_idx = wrap_idx(ptr, i);
            end
        end
    end

    assign req_if.req_ready = gnt_any ? (ONE << gnt_idx) : '0;
    assign req_if.rsp_valid = rsp_valid_q;
    assign req_if.rsp_data  = rsp_data_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr         <= '0;
            comp_init_o <= 1'b0;
            comp_data_o <= '0;
            tag_vld     <= '0;
            tag_idx     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            err_o       <= 1'b0;
        end else begin
            comp_init_o <= gnt_any;
            if (gnt_any) begin
                comp_data_o <= req_if.req_data[gnt_idx];
                ptr         <= (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);
            end
            tag_vld <= {tag_vld[LAST-1:0], gnt_any};
            tag_idx <= {tag_idx[LAST-1:0], gnt_idx};

            // A result is only routed when the owner tag lines up with the done strobe.
            rsp_valid_q <= '0;
            if (comp_done_i && tag_vld[LAST]) begin
                rsp_valid_q <= ONE << tag_idx[LAST];
                rsp_data_q  <= comp_data_i;
            end
            if (comp_done_i != tag_vld[LAST]) err_o <= 1'b1;
        end
    end

    assign busy_o = comp_init_o | (|tag_vld) | (|rsp_valid_q);
endmodule
